// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: serializes writes from NREQ requesters into one shared
// WIDTH-bit register using a grant/commit handshake.
// Build option: define ARB_ROUND_ROBIN_EN for a rotating priority pointer.
// Without it, the lowest requesting index always wins.
module shared_reg_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      q,
  output logic                  busy
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t        state;
  logic [IW-1:0] winner;
  logic [IW-1:0] pick;
  logic          pick_vld;
  int unsigned   idx;

`ifdef ARB_ROUND_ROBIN_EN
  logic [IW-1:0] ptr;
`endif

  // Winner selection: first set request scanning upward from the priority start
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    idx      = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      idx = (32'(ptr) + k) % NREQ;
`else
      idx = k;
`endif
      if (!pick_vld && req[IW'(idx)]) begin
        pick_vld = 1'b1;
        pick     = IW'(idx);
      end
    end
  end

  // Handshake FSM with registered grant/ack/register/busy outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      winner <= '0;
      gnt    <= '0;
      ack    <= '0;
      q      <= '0;
      busy   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          ack <= '0;
          if (pick_vld) begin
            winner <= pick;
            gnt    <= NREQ'(1) << pick;
            busy   <= 1'b1;
            state  <= GRANT;
          end
        end
        GRANT: begin
          gnt <= '0;
          if (req[winner]) begin
            q     <= wdata[32'(winner)*WIDTH +: WIDTH];
            ack   <= NREQ'(1) << winner;
            state <= COMMIT;
          end else begin
            // requester withdrew: abandon without writing
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        COMMIT: begin
          ack   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
`ifdef ARB_ROUND_ROBIN_EN
          ptr   <= (winner == IW'(NREQ-1)) ? '0 : winner + 1'b1;
`endif
        end
        default: begin
          gnt   <= '0;
          ack   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
